agc_stat_engine: RTL
====================

Name: agc_stat_engine

Overview:
- Parametrised multi-channel successor to the single-channel AGC measurement path.
- For NCHAN ADC streams it accumulates, over a programmable window:
  - the sum of squared samples;
  - the count of samples above +threshold;
  - the count of samples below -threshold.
- At window end it latches per-channel results into hold registers and pulses done. A registered read port then serves the results to the register/bus logic.
- Sits in the ADC clock domain, between the sample unpacker and the AGC scale/offset stage.

Parameters:
- NCHAN, 8, number of channels.
- NSAMP, 8, samples per channel per clock.
- SAMPLE_BITS, 12, signed sample width.
- WIN_BITS, 20, width of window length.
- ACC_BITS, 48, square accumulator width (saturating).
- CNT_BITS, 24, gt/lt counter width (saturating).

Ports:
- clk_i  in  1  ADC-domain clock.
- rst_i  in  1  synchronous active-high reset.
- dat_i  in  NCHAN*NSAMP*SAMPLE_BITS  packed signed samples; chan c, sample s at [(c*NSAMP+s)*SAMPLE_BITS +: SAMPLE_BITS].
- start_i  in  1  one-cycle pulse: clear accumulators, begin window.
- abort_i  in  1  one-cycle pulse: stop without latching.
- window_i  in  WIN_BITS  window length in clocks; sampled on start_i.
- thresh_i  in  SAMPLE_BITS-1  unsigned threshold magnitude; sampled on start_i.
- busy_o  out  1  high in RUN and FLUSH.
- done_o  out  1  one-cycle pulse: hold registers updated.
- rd_req_i  in  1  read request.
- rd_chan_i  in  $clog2(NCHAN)  channel to read.
- rd_valid_o  out  1  read data valid.
- rd_sq_o  out  ACC_BITS  square sum of selected channel.
- rd_gt_o  out  CNT_BITS  count of samples > +thresh.
- rd_lt_o  out  CNT_BITS  count of samples < -thresh.

Behaviour:
- Interface: one clock; reset is synchronous and active-high (clk_i, rst_i).
- Reset values:
  - state IDLE;
  - busy_o=0, done_o=0, rd_valid_o=0;
  - rd_* data 0;
  - all accumulators, counters and hold registers 0.
- FSM transitions:
  - IDLE -> RUN on start_i.
  - RUN -> FLUSH when the window counter reaches the latched window.
  - FLUSH lasts 3 cycles, then LATCH.
  - LATCH lasts 1 cycle, then IDLE.
- Timing, with start_i at cycle 0 and W = latched window:
  - beats on cycles 1..W are included; all others excluded;
  - the qualifier travels with the 3-stage data pipeline (register, square/compare, per-channel sum);
  - hold registers update on the edge ending the last FLUSH cycle;
  - done_o is high on cycle W+4 (the LATCH cycle).
- window_i=0 is treated as 1.
- Arithmetic:
  - square = sample*sample, unsigned 2*SAMPLE_BITS-1 bits;
  - per-channel per-clock sum of NSAMP squares, added to the channel accumulator;
  - the accumulator saturates at all-ones and never wraps.
- Threshold compares:
  - gt increments per sample with sample > +thresh;
  - lt increments per sample with sample < -thresh;
  - both use signed compares; each counter adds up to NSAMP per clock and saturates at all-ones.
- start_i while busy: restart.
  - Accumulators clear.
  - window_i and thresh_i are re-sampled.
  - In-flight pipeline beats are discarded.
  - Hold registers are unchanged.
  - No done_o for the aborted window.
- abort_i:
  - any state -> IDLE next cycle, busy_o=0, no done_o, hold registers unchanged.
  - start_i and abort_i in the same cycle: start_i wins.
- Read port:
  - rd_req_i at cycle t gives rd_valid_o=1 at t+1, with data from the hold registers as they stand after edge t.
  - A read issued in the done_o cycle returns new values.
  - rd_chan_i >= NCHAN returns zeros with rd_valid_o=1.
  - Reads are allowed in any state; back-to-back reads are allowed, one per clock.
- rst_i mid-window: immediate return to reset values; hold registers cleared.

Optional Feature:
- Macro: AGC_STAT_PEAK_EN.
- When defined:
  - adds port rd_peak_o, out, SAMPLE_BITS;
  - tracks the per-channel max |sample| over the window, with |-2^(SAMPLE_BITS-1)| clamped to 2^(SAMPLE_BITS-1)-1;
  - peak is latched and cleared alongside the other stats.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Constant samples:
  - Stimulus: all channels constant +100, thresh 50, window 16.
  - Required: done_o on cycle 20; per channel sq=16*8*10000=1280000, gt=128, lt=0.
- Alternating per channel:
  - Stimulus: chan c samples alternate +(c+1)*10 and -(c+1)*10 per clock, thresh 25, window 4.
  - Required: chans 0,1: gt=lt=0; chans 2-7: gt=lt=16; sq=32*((c+1)*10)^2.
- Saturation:
  - Stimulus: CNT_BITS=4, samples -2048, thresh 0, window 8.
  - Required: lt=15 (saturated), gt=0; sq=64*4194304, no wrap.
- Restart and abort:
  - Stimulus: start_i at cycle 5 of a window-100 run.
  - Required: single done_o at start2+104, sums cover only the new window.
  - Stimulus: abort_i mid-run.
  - Required: busy_o=0 next cycle, no done_o, reads return prior results.
- Read port:
  - Stimulus: rd_req_i in the done_o cycle, back-to-back reads of chans 0..7, then rd_chan_i=NCHAN.
  - Required: rd_valid_o one cycle after each request; new values returned; the out-of-range read returns zeros.
- Reset:
  - Stimulus: rst_i mid-FLUSH.
  - Required: no done_o; all outputs 0; the next start_i works normally.

Source files
------------

// File: rtl/agc_stat_engine.sv
// Multi-channel windowed statistics: per-channel saturating sum of squares and +/- threshold crossing counts.
// Define AGC_STAT_PEAK_EN to add per-channel peak |sample| tracking and the rd_peak_o port.
module agc_stat_engine #(
  parameter int NCHAN       = 8,
  parameter int NSAMP       = 8,
  parameter int SAMPLE_BITS = 12,
  parameter int WIN_BITS    = 20,
  parameter int ACC_BITS    = 48,
  parameter int CNT_BITS    = 24
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NCHAN*NSAMP*SAMPLE_BITS-1:0]   dat_i,
  input  logic                                 start_i,
  input  logic                                 abort_i,
  input  logic [WIN_BITS-1:0]                  window_i,
  input  logic [SAMPLE_BITS-2:0]               thresh_i,
  output logic                                 busy_o,
  output logic                                 done_o,
  input  logic                                 rd_req_i,
  input  logic [$clog2(NCHAN)-1:0]             rd_chan_i,
  output logic                                 rd_valid_o,
  output logic [ACC_BITS-1:0]                  rd_sq_o,
  output logic [CNT_BITS-1:0]                  rd_gt_o,
  output logic [CNT_BITS-1:0]                  rd_lt_o
`ifdef AGC_STAT_PEAK_EN
  ,
  output logic [SAMPLE_BITS-1:0]               rd_peak_o
`endif
);

  localparam int          SQ_BITS  = 2*SAMPLE_BITS-1;
  localparam int          SUM_BITS = SQ_BITS + $clog2(NSAMP);
  localparam int          NC_BITS  = $clog2(NSAMP+1);
  localparam int unsigned NCHAN_U  = NCHAN;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_LATCH} state_t;

  state_t                         r_state, w_state_nxt;
  logic                           w_latch;
  logic [WIN_BITS-1:0]            r_win, r_wcnt;
  logic [1:0]                     r_fcnt;
  logic [SAMPLE_BITS-2:0]         r_thr;
  logic                           r_busy, r_done;

  logic [NCHAN*NSAMP*SAMPLE_BITS-1:0] r_s1_dat;
  logic                           r_s1_v, r_s2_v;
  logic [SUM_BITS-1:0]            w_sum [NCHAN];
  logic [SUM_BITS-1:0]            r_s2_sum [NCHAN];
  logic [NC_BITS-1:0]             w_gt [NCHAN];
  logic [NC_BITS-1:0]             w_lt [NCHAN];
  logic [NC_BITS-1:0]             r_s2_gt [NCHAN];
  logic [NC_BITS-1:0]             r_s2_lt [NCHAN];
  logic [ACC_BITS-1:0]            r_acc [NCHAN];
  logic [CNT_BITS-1:0]            r_gt [NCHAN];
  logic [CNT_BITS-1:0]            r_lt [NCHAN];
  logic [ACC_BITS-1:0]            r_h_sq [NCHAN];
  logic [CNT_BITS-1:0]            r_h_gt [NCHAN];
  logic [CNT_BITS-1:0]            r_h_lt [NCHAN];

  int unsigned                    w_rd_ch;
  logic [ACC_BITS-1:0]            w_rd_sq, r_rd_sq;
  logic [CNT_BITS-1:0]            w_rd_gt, w_rd_lt, r_rd_gt, r_rd_lt;
  logic                           r_rd_v;

`ifdef AGC_STAT_PEAK_EN
  logic [SAMPLE_BITS-1:0]         w_pk [NCHAN];
  logic [SAMPLE_BITS-1:0]         r_s2_pk [NCHAN];
  logic [SAMPLE_BITS-1:0]         r_pk [NCHAN];
  logic [SAMPLE_BITS-1:0]         r_h_pk [NCHAN];
  logic [SAMPLE_BITS-1:0]         w_rd_pk, r_rd_pk;

  // Magnitude of a sample; the most negative code clamps to the largest positive value.
  function automatic logic [SAMPLE_BITS-1:0] abs_f(input logic signed [SAMPLE_BITS-1:0] x);
    logic [SAMPLE_BITS-1:0] m;
    m = x[SAMPLE_BITS-1] ? SAMPLE_BITS'(-x) : x;
    return m[SAMPLE_BITS-1] ? {1'b0, {(SAMPLE_BITS-1){1'b1}}} : m;
  endfunction
`endif

  function automatic logic [SQ_BITS-1:0] sq_f(input logic signed [SAMPLE_BITS-1:0] x);
    logic signed [2*SAMPLE_BITS-1:0] xe;
    logic signed [2*SAMPLE_BITS-1:0] p;
    xe = (2*SAMPLE_BITS)'(x);
    p  = xe * xe;
    return p[SQ_BITS-1:0];
  endfunction

  function automatic logic gt_f(input logic signed [SAMPLE_BITS-1:0] x, input logic [SAMPLE_BITS-2:0] t);
    logic signed [SAMPLE_BITS:0] xe, te;
    xe = (SAMPLE_BITS+1)'(x);
    te = $signed({2'b00, t});
    return xe > te;
  endfunction

  function automatic logic lt_f(input logic signed [SAMPLE_BITS-1:0] x, input logic [SAMPLE_BITS-2:0] t);
    logic signed [SAMPLE_BITS:0] xe, te;
    xe = (SAMPLE_BITS+1)'(x);
    te = $signed({2'b00, t});
    return xe < -te;
  endfunction

  function automatic logic [ACC_BITS-1:0] sat_acc_f(input logic [ACC_BITS-1:0] a, input logic [SUM_BITS-1:0] b);
    logic [ACC_BITS:0] s;
    s = {1'b0, a} + (ACC_BITS+1)'(b);
    return s[ACC_BITS] ? {ACC_BITS{1'b1}} : s[ACC_BITS-1:0];
  endfunction

  function automatic logic [CNT_BITS-1:0] sat_cnt_f(input logic [CNT_BITS-1:0] a, input logic [NC_BITS-1:0] b);
    logic [CNT_BITS:0] s;
    s = {1'b0, a} + (CNT_BITS+1)'(b);
    return s[CNT_BITS] ? {CNT_BITS{1'b1}} : s[CNT_BITS-1:0];
  endfunction

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next state; start_i outranks abort_i, and both pre-empt the latch.
  always_comb begin
    w_state_nxt = r_state;
    w_latch     = 1'b0;
    if (start_i) begin
      w_state_nxt = S_RUN;
    end else if (abort_i) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  w_state_nxt = S_IDLE;
        S_RUN:   w_state_nxt = (r_wcnt == r_win) ? S_FLUSH : S_RUN;
        S_FLUSH: begin
          if (r_fcnt == 2'd2) begin
            w_state_nxt = S_LATCH;
            w_latch     = 1'b1;
          end else begin
            w_state_nxt = S_FLUSH;
          end
        end
        S_LATCH: w_state_nxt = S_IDLE;
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Window/flush counters and the configuration captured at start.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_win  <= '0;
      r_thr  <= '0;
      r_wcnt <= '0;
      r_fcnt <= 2'd0;
    end else if (start_i) begin
      r_win  <= (window_i == '0) ? WIN_BITS'(1) : window_i;
      r_thr  <= thresh_i;
      r_wcnt <= WIN_BITS'(1);
      r_fcnt <= 2'd0;
    end else begin
      r_wcnt <= (r_state == S_RUN) ? r_wcnt + WIN_BITS'(1) : r_wcnt;
      r_fcnt <= (r_state == S_FLUSH) ? r_fcnt + 2'd1 : 2'd0;
    end
  end

  // Registered status outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      r_busy <= (w_state_nxt == S_RUN) || (w_state_nxt == S_FLUSH);
      r_done <= w_latch;
    end
  end

  // Per-channel squares and threshold crossings of the stage-1 beat.
  always_comb begin
    for (int c = 0; c < NCHAN; c++) begin
      w_sum[c] = '0;
      w_gt[c]  = '0;
      w_lt[c]  = '0;
`ifdef AGC_STAT_PEAK_EN
      w_pk[c]  = '0;
`endif
      for (int s = 0; s < NSAMP; s++) begin
        w_sum[c] = w_sum[c] + SUM_BITS'(sq_f(r_s1_dat[(c*NSAMP+s)*SAMPLE_BITS +: SAMPLE_BITS]));
        w_gt[c]  = w_gt[c] + NC_BITS'(gt_f(r_s1_dat[(c*NSAMP+s)*SAMPLE_BITS +: SAMPLE_BITS], r_thr));
        w_lt[c]  = w_lt[c] + NC_BITS'(lt_f(r_s1_dat[(c*NSAMP+s)*SAMPLE_BITS +: SAMPLE_BITS], r_thr));
`ifdef AGC_STAT_PEAK_EN
        w_pk[c]  = (abs_f(r_s1_dat[(c*NSAMP+s)*SAMPLE_BITS +: SAMPLE_BITS]) > w_pk[c]) ?
                   abs_f(r_s1_dat[(c*NSAMP+s)*SAMPLE_BITS +: SAMPLE_BITS]) : w_pk[c];
`endif
      end
    end
  end

  // Stages 1-2: the in-window qualifier travels with the data; start/abort drop in-flight beats.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_v   <= 1'b0;
      r_s2_v   <= 1'b0;
      r_s1_dat <= '0;
      for (int c = 0; c < NCHAN; c++) begin
        r_s2_sum[c] <= '0;
        r_s2_gt[c]  <= '0;
        r_s2_lt[c]  <= '0;
`ifdef AGC_STAT_PEAK_EN
        r_s2_pk[c]  <= '0;
`endif
      end
    end else begin
      r_s1_v   <= (r_state == S_RUN) && !start_i && !abort_i;
      r_s2_v   <= r_s1_v && !start_i && !abort_i;
      r_s1_dat <= dat_i;
      for (int c = 0; c < NCHAN; c++) begin
        r_s2_sum[c] <= w_sum[c];
        r_s2_gt[c]  <= w_gt[c];
        r_s2_lt[c]  <= w_lt[c];
`ifdef AGC_STAT_PEAK_EN
        r_s2_pk[c]  <= w_pk[c];
`endif
      end
    end
  end

  // Stage 3: saturating per-channel accumulation, cleared on start.
  always_ff @(posedge clk_i) begin
    if (rst_i || start_i) begin
      for (int c = 0; c < NCHAN; c++) begin
        r_acc[c] <= '0;
        r_gt[c]  <= '0;
        r_lt[c]  <= '0;
`ifdef AGC_STAT_PEAK_EN
        r_pk[c]  <= '0;
`endif
      end
    end else if (r_s2_v) begin
      for (int c = 0; c < NCHAN; c++) begin
        r_acc[c] <= sat_acc_f(r_acc[c], r_s2_sum[c]);
        r_gt[c]  <= sat_cnt_f(r_gt[c], r_s2_gt[c]);
        r_lt[c]  <= sat_cnt_f(r_lt[c], r_s2_lt[c]);
`ifdef AGC_STAT_PEAK_EN
        r_pk[c]  <= (r_s2_pk[c] > r_pk[c]) ? r_s2_pk[c] : r_pk[c];
`endif
      end
    end
  end

  // Hold registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int c = 0; c < NCHAN; c++) begin
        r_h_sq[c] <= '0;
        r_h_gt[c] <= '0;
        r_h_lt[c] <= '0;
`ifdef AGC_STAT_PEAK_EN
        r_h_pk[c] <= '0;
`endif
      end
    end else if (w_latch) begin
      for (int c = 0; c < NCHAN; c++) begin
        r_h_sq[c] <= r_acc[c];
        r_h_gt[c] <= r_gt[c];
        r_h_lt[c] <= r_lt[c];
`ifdef AGC_STAT_PEAK_EN
        r_h_pk[c] <= r_pk[c];
`endif
      end
    end
  end

  // Read mux sees the hold registers as they will stand after this edge.
  always_comb begin
    w_rd_ch = 32'(rd_chan_i);
    w_rd_sq = '0;
    w_rd_gt = '0;
    w_rd_lt = '0;
`ifdef AGC_STAT_PEAK_EN
    w_rd_pk = '0;
`endif
    if (w_rd_ch < NCHAN_U) begin
      if (w_latch) begin
        w_rd_sq = r_acc[rd_chan_i];
        w_rd_gt = r_gt[rd_chan_i];
        w_rd_lt = r_lt[rd_chan_i];
`ifdef AGC_STAT_PEAK_EN
        w_rd_pk = r_pk[rd_chan_i];
`endif
      end else begin
        w_rd_sq = r_h_sq[rd_chan_i];
        w_rd_gt = r_h_gt[rd_chan_i];
        w_rd_lt = r_h_lt[rd_chan_i];
`ifdef AGC_STAT_PEAK_EN
        w_rd_pk = r_h_pk[rd_chan_i];
`endif
      end
    end else begin
      w_rd_sq = '0;
    end
  end

  // Registered read port.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_rd_v  <= 1'b0;
      r_rd_sq <= '0;
      r_rd_gt <= '0;
      r_rd_lt <= '0;
`ifdef AGC_STAT_PEAK_EN
      r_rd_pk <= '0;
`endif
    end else begin
      r_rd_v <= rd_req_i;
      if (rd_req_i) begin
        r_rd_sq <= w_rd_sq;
        r_rd_gt <= w_rd_gt;
        r_rd_lt <= w_rd_lt;
`ifdef AGC_STAT_PEAK_EN
        r_rd_pk <= w_rd_pk;
`endif
      end
    end
  end

  assign busy_o     = r_busy;
  assign done_o     = r_done;
  assign rd_valid_o = r_rd_v;
  assign rd_sq_o    = r_rd_sq;
  assign rd_gt_o    = r_rd_gt;
  assign rd_lt_o    = r_rd_lt;
`ifdef AGC_STAT_PEAK_EN
  assign rd_peak_o  = r_rd_pk;
`endif

endmodule
